mc_datapath_param: RTL and testbench
====================================

// Module: mc_datapath_param
// PURPOSE
//  Parametrised multi-cycle CPU datapath: PC, IR, register file, A/B/ALUOut/MDR latches and all datapath muxes.
//  Driven cycle-by-cycle by the multi-cycle control unit; talks to an external ALU and a variable-latency memory.
//  Adds over the 16-bit generation: width/RF-size generics, mem_req/mem_ready handshake with stall, registered output port with valid strobe.
// PARAMETERS
//  WORD_SIZE   16      datapath/instruction width; >=12
//  REG_ADDR_W  2       RF address bits; RF holds 2**REG_ADDR_W words
//  IMM_W       8       immediate width, sign-extended to WORD_SIZE
//  RESET_PC    0       PC value after reset
//  LINK_REG    2**REG_ADDR_W-1  destination index when reg_dst==2
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high
//  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, out_en   in  1   control strobes
//  pc_source      in   2   0 ALU result, 1 ALUOut, 2 jump target, 3 RF read port 1
//  alu_src_b      in   2   0 B latch, 1 constant 1, 2 sign-ext imm, 3 zero
//  reg_dst        in   2   0 rt, 1 rd, 2 LINK_REG
//  inst_out       out  W   IR contents to control unit
//  stall          out  1   memory op in flight; control holds its outputs
//  alu_a, alu_b   out  W   ALU operands;  alu_c in W result;  alu_zero in 1
//  mem_addr       out  W   i_or_d ? ALUOut : PC
//  mem_wdata      out  W   B latch
//  mem_req        out  1   registered request;  mem_we out 1 registered write flag
//  mem_rdata      in   W   read data, valid with mem_ready;  mem_ready in 1
//  output_port    out  W   registered WWD value;  output_valid out 1 one-cycle strobe
// BEHAVIOUR
//  Fields (W=WORD_SIZE,R=REG_ADDR_W): rs=IR[W-5 -:R], rt=next R bits down, rd=next R bits down; imm=IR[IMM_W-1:0]; jump target={PC[W-1:W-4],IR[W-5:0]}.
//  Reset: PC=RESET_PC; IR,A,B,ALUOut,MDR,all RF words,output_port=0; mem_req,mem_we,output_valid=0; FSM=IDLE.
//  Every clock (stall=0): A<=RF[rs], B<=RF[rt], ALUOut<=alu_c. RF read combinational; RF write on clock when reg_write.
//  RF write data = mem_to_reg ? MDR : ALUOut. Same-cycle read/write of one index returns old value.
//  PC update when pc_write | (pc_write_cond & alu_zero); pc_source=3 uses combinational RF[rs].
//  Memory FSM: IDLE --(mem_read|mem_write)--> REQ (mem_req=1, mem_we=mem_write, addr held). REQ --mem_ready--> IDLE.
//  stall = (mem_read|mem_write) & !(state==REQ & mem_ready). Min memory latency: 2 cycles (request, ready).
//  While stall=1: PC, IR, RF, A, B, ALUOut, MDR, output_port all hold; mem_addr/mem_wdata stable.
//  Completion edge (REQ & mem_ready): MDR<=mem_rdata on read; IR<=mem_rdata if ir_write; other writes enabled by their strobes as normal.
//  mem_read & mem_write both high: treated as write; mem_rdata ignored.
//  mem_ready in IDLE ignored. Control dropping mem op while in REQ: illegal; FSM stays REQ until mem_ready.
//  out_en (stall=0): output_port<=RF[rs], output_valid=1 next cycle only; otherwise output_valid=0, port holds.
//  reset mid-transaction: FSM IDLE, mem_req=0 immediately (async); pending response discarded.
//  All arithmetic modulo 2**WORD_SIZE; PC increment is via ALU (alu_src_a=0, alu_src_b=1).
// CONFIGURATION
//  DP_PERF_CNT_EN defined: extra outputs cyc_cnt, stall_cnt, instr_cnt (32 bits each, reset 0, wrap);
//   cyc_cnt +1 every clock, stall_cnt +1 per cycle stall=1, instr_cnt +1 per IR load completion.
//  Undefined: the three ports still exist, tied to 0; no counter flops.
// TESTING
//  Reset with PC=RESET_PC=0x0010 -> mem_addr=0x0010, stall=0, mem_req=0, output_valid=0, all RF reads 0.
//  Fetch, mem_ready 3 cycles after req, mem_rdata=0x6A05 -> stall high 4 cycles, IR=0x6A05 on ready edge, PC held until then.
//  reg_write reg_dst=1 ALUOut=0x1234, rd=1 -> RF[1]=0x1234 next edge; same-cycle read of RF[1] returns old 0.
//  Store: B=0xBEEF, ALUOut=0x0040, i_or_d=1, mem_write -> mem_req=1,mem_we=1,addr 0x0040,wdata 0xBEEF held until ready.
//  pc_write_cond, alu_zero=1, pc_source=1, ALUOut=0x0022 -> PC=0x0022; alu_zero=0 -> PC unchanged.
//  reset pulse while FSM=REQ -> mem_req=0 same cycle; later mem_ready ignored; DP_PERF_CNT_EN: counters 0.

Source files
------------

// File: rtl/mc_datapath_param.sv
// Parametrised multi-cycle CPU datapath with a req/ready memory port that stalls the control unit.
// Define DP_PERF_CNT_EN to build the cycle/stall/instruction counters; otherwise those ports read 0.
module mc_datapath_param #(
  parameter int                   WORD_SIZE  = 16,
  parameter int                   REG_ADDR_W = 2,
  parameter int                   IMM_W      = 8,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   LINK_REG   = 2**REG_ADDR_W - 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pc_write_i,
  input  logic                 pc_write_cond_i,
  input  logic                 i_or_d_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 mem_to_reg_i,
  input  logic                 ir_write_i,
  input  logic                 alu_src_a_i,
  input  logic                 reg_write_i,
  input  logic                 out_en_i,
  input  logic [1:0]           pc_source_i,
  input  logic [1:0]           alu_src_b_i,
  input  logic [1:0]           reg_dst_i,
  output logic [WORD_SIZE-1:0] inst_out_o,
  output logic                 stall_o,
  output logic [WORD_SIZE-1:0] alu_a_o,
  output logic [WORD_SIZE-1:0] alu_b_o,
  input  logic [WORD_SIZE-1:0] alu_c_i,
  input  logic                 alu_zero_i,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  input  logic [WORD_SIZE-1:0] mem_rdata_i,
  input  logic                 mem_ready_i,
  output logic [WORD_SIZE-1:0] output_port_o,
  output logic                 output_valid_o,
  output logic [31:0]          cyc_cnt_o,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          instr_cnt_o
);

  localparam int W    = WORD_SIZE;
  localparam int R    = REG_ADDR_W;
  localparam int NREG = 2**REG_ADDR_W;

  typedef enum logic {IDLE, REQ} memState_e;

  memState_e    state_q, state_d;
  logic         memReq_q, memWe_q, memWe_d;
  logic [W-1:0] pc_q, ir_q, a_q, b_q, aluOut_q, mdr_q, outPort_q;
  logic         outValid_q;
  logic [W-1:0] rf_q [NREG];

  logic [R-1:0] rs, rt, rd, wAddr;
  logic [W-1:0] immExt, jumpTarget, aluA, aluB, pcNext, wData;
  logic         memOp, memDone, stall, loadRead, pcEn;

  assign rs         = ir_q[W-5 -: R];
  assign rt         = ir_q[W-5-R -: R];
  assign rd         = ir_q[W-5-2*R -: R];
  assign immExt     = {{(W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign jumpTarget = {pc_q[W-1:W-4], ir_q[W-5:0]};

  assign memOp    = mem_read_i | mem_write_i;
  assign memDone  = (state_q == REQ) & mem_ready_i;
  assign stall    = memOp & ~memDone;
  // A write (including read+write) never loads MDR/IR from the bus.
  assign loadRead = memDone & ~memWe_q;
  assign pcEn     = pc_write_i | (pc_write_cond_i & alu_zero_i);

  always_comb begin
    state_d = state_q;
    memWe_d = memWe_q;
    case (state_q)
      IDLE: if (memOp) begin
        state_d = REQ;
        memWe_d = mem_write_i;
      end
      REQ: if (mem_ready_i) begin
        state_d = IDLE;
        memWe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aluA  = alu_src_a_i ? a_q : pc_q;
    wData = mem_to_reg_i ? mdr_q : aluOut_q;
    case (alu_src_b_i)
      2'd0:    aluB = b_q;
      2'd1:    aluB = W'(1);
      2'd2:    aluB = immExt;
      default: aluB = '0;
    endcase
    case (pc_source_i)
      2'd0:    pcNext = alu_c_i;
      2'd1:    pcNext = aluOut_q;
      2'd2:    pcNext = jumpTarget;
      default: pcNext = rf_q[rs];
    endcase
    case (reg_dst_i)
      2'd1:    wAddr = rd;
      2'd2:    wAddr = R'(LINK_REG);
      default: wAddr = rt;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      memReq_q <= 1'b0;
      memWe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      memReq_q <= (state_d == REQ);
      memWe_q  <= memWe_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluOut_q   <= '0;
      mdr_q      <= '0;
      outPort_q  <= '0;
      outValid_q <= 1'b0;
    end else if (!stall) begin
      a_q        <= rf_q[rs];
      b_q        <= rf_q[rt];
      aluOut_q   <= alu_c_i;
      outValid_q <= out_en_i;
      if (pcEn)                   pc_q      <= pcNext;
      if (loadRead)               mdr_q     <= mem_rdata_i;
      if (loadRead && ir_write_i) ir_q      <= mem_rdata_i;
      if (out_en_i)               outPort_q <= rf_q[rs];
    end else begin
      outValid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (!stall && reg_write_i) begin
      rf_q[wAddr] <= wData;
    end
  end

`ifdef DP_PERF_CNT_EN
  logic [31:0] cycCnt_q, stallCnt_q, instrCnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycCnt_q   <= '0;
      stallCnt_q <= '0;
      instrCnt_q <= '0;
    end else begin
      cycCnt_q <= cycCnt_q + 32'd1;
      if (stall)                  stallCnt_q <= stallCnt_q + 32'd1;
      if (loadRead && ir_write_i) instrCnt_q <= instrCnt_q + 32'd1;
    end
  end

  assign cyc_cnt_o   = cycCnt_q;
  assign stall_cnt_o = stallCnt_q;
  assign instr_cnt_o = instrCnt_q;
`else
  assign cyc_cnt_o   = '0;
  assign stall_cnt_o = '0;
  assign instr_cnt_o = '0;
`endif

  assign inst_out_o     = ir_q;
  assign stall_o        = stall;
  assign alu_a_o        = aluA;
  assign alu_b_o        = aluB;
  assign mem_addr_o     = i_or_d_i ? aluOut_q : pc_q;
  assign mem_wdata_o    = b_q;
  assign mem_req_o      = memReq_q;
  assign mem_we_o       = memWe_q;
  assign output_port_o  = outPort_q;
  assign output_valid_o = outValid_q;

endmodule

// File: tb/tb_mc_datapath_param.sv
// Bench for mc_datapath_param: acts as control unit, ALU and variable-latency memory, and runs a
// random instruction stream against an architectural model; memory requests and WWD outputs go through a scoreboard.
`timescale 1ns/1ps
module tb_mc_datapath_param;

  localparam logic [15:0] RST_PC = 16'h0010;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       aluSrcA;
    logic       regWrite;
    logic       outEn;
    logic [1:0] pcSource;
    logic [1:0] aluSrcB;
    logic [1:0] regDst;
  } ctrl_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } memReq_t;

  logic        clk, reset;
  ctrl_t       ctrl;
  logic [15:0] instOut, aluA, aluB, aluC, memAddr, memWdata, memRdata, outPort;
  logic        stall, aluZero, memReq, memWe, memReady, outValid, respReady, forceReady;
  logic [31:0] cycCnt, stallCnt, instrCnt;

  mc_datapath_param #(
    .WORD_SIZE(16), .REG_ADDR_W(2), .IMM_W(8), .RESET_PC(RST_PC), .LINK_REG(3)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .pc_write_i(ctrl.pcWrite), .pc_write_cond_i(ctrl.pcWriteCond), .i_or_d_i(ctrl.iOrD),
    .mem_read_i(ctrl.memRead), .mem_write_i(ctrl.memWrite), .mem_to_reg_i(ctrl.memToReg),
    .ir_write_i(ctrl.irWrite), .alu_src_a_i(ctrl.aluSrcA), .reg_write_i(ctrl.regWrite),
    .out_en_i(ctrl.outEn), .pc_source_i(ctrl.pcSource), .alu_src_b_i(ctrl.aluSrcB),
    .reg_dst_i(ctrl.regDst), .inst_out_o(instOut), .stall_o(stall),
    .alu_a_o(aluA), .alu_b_o(aluB), .alu_c_i(aluC), .alu_zero_i(aluZero),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_req_o(memReq), .mem_we_o(memWe),
    .mem_rdata_i(memRdata), .mem_ready_i(memReady),
    .output_port_o(outPort), .output_valid_o(outValid),
    .cyc_cnt_o(cycCnt), .stall_cnt_o(stallCnt), .instr_cnt_o(instrCnt)
  );

  // Bench ALU adds; its zero flag reports equal operands (used for branch compare).
  assign aluC     = aluA + aluB;
  assign aluZero  = (aluA == aluB);
  assign memReady = respReady | forceReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          stallSum = 0, fetchCount = 0;
  int          lat, cnt, lastLat = 0, fixedLat = 0;
  bit          busy = 0, holdReady = 0, isFetch = 0, prevReq = 0;
  logic [15:0] fetchWord, heldAddr, heldData;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] regs [4];
  logic [15:0] pc;
  memReq_t     reqQ [$];
  logic [15:0] outQ [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memRead(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 16'hC3A5);
  endfunction

  // Memory: answers each request after 1..4 request cycles; garbage on the bus otherwise.
  always @(negedge clk) begin
    respReady = 1'b0;
    memRdata  = 16'($urandom);
    if (reset || !memReq) begin
      busy = 0;
    end else begin
      if (!busy) begin
        busy    = 1;
        cnt     = 0;
        lat     = (fixedLat != 0) ? fixedLat : int'($urandom_range(1, 4));
        lastLat = lat;
      end
      cnt++;
      if (cnt == lat && !holdReady) begin
        respReady = 1'b1;
        if (memWe) mem[memAddr] = memWdata;
        else       memRdata = isFetch ? fetchWord : memRead(memAddr);
      end
    end
  end

  // Scoreboard monitor: compares each new request and each output strobe with the queued expectation.
  always @(negedge clk) begin
    memReq_t e;
    if (reset) begin
      prevReq = 0;
    end else begin
      if (memReq && !prevReq) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpected mem_req", 32'(memReq), 32'd0);
        end else begin
          e = reqQ.pop_front();
          checkOutput("mem_we", 32'(memWe), 32'(e.we));
          checkOutput("mem_addr", 32'(memAddr), 32'(e.addr));
          if (e.we) checkOutput("mem_wdata", 32'(memWdata), 32'(e.wdata));
          heldAddr = memAddr;
          heldData = memWdata;
        end
      end else if (memReq) begin
        checkOutput("mem_addr held", 32'(memAddr), 32'(heldAddr));
        checkOutput("mem_wdata held", 32'(memWdata), 32'(heldData));
      end
      if (outValid) begin
        if (outQ.size() == 0) checkOutput("unexpected output_valid", 32'(outValid), 32'd0);
        else checkOutput("output_port", 32'(outPort), 32'(outQ.pop_front()));
      end
      prevReq = memReq;
    end
  end

  // Holds one control word until the datapath stops stalling, then lets the edge through.
  task automatic applyStimulus(input ctrl_t c, output int stalls);
    ctrl   = c;
    stalls = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!stall) break;
      stalls++;
      if (stalls > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL stall timeout: still stalled after %0d cycles, expected release", stalls);
        break;
      end
      @(posedge clk);
      #1;
    end
    stallSum += stalls;
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [15:0] instr);
    ctrl_t       c;
    int          st;
    logic [3:0]  op;
    logic [1:0]  rs, rt, rd;
    logic [15:0] sx, addr, rdVal;
    op   = instr[15:12];
    rs   = instr[11:10];
    rt   = instr[9:8];
    rd   = instr[7:6];
    sx   = {{8{instr[7]}}, instr[7:0]};
    addr = regs[rs] + sx;

    reqQ.push_back('{we: 1'b0, addr: pc, wdata: 16'h0});
    fetchWord = instr;
    isFetch   = 1;
    c = '0; c.memRead = 1; c.irWrite = 1; c.pcWrite = 1; c.aluSrcB = 2'd1;
    applyStimulus(c, st);
    isFetch = 0;
    fetchCount++;
    checkOutput("fetch stall cycles", 32'(st), 32'(lastLat));
    checkOutput("inst_out", 32'(instOut), 32'(instr));
    pc = pc + 16'd1;

    c = '0; c.aluSrcB = 2'd2;
    applyStimulus(c, st);

    case (op)
      4'd1: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'd2; applyStimulus(c, st);
        c = '0; c.regWrite = 1; c.regDst = 2'd0; applyStimulus(c, st);
        regs[rt] = regs[rs] + sx;
      end
      4'd2: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'd0; applyStimulus(c, st);
        outQ.push_back(regs[rs]);
        c = '0; c.regWrite = 1; c.regDst = 2'd1; c.outEn = 1; applyStimulus(c, st);
        regs[rd] = regs[rs] + regs[rt];
      end
      4'd4, 4'd5: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'd2; applyStimulus(c, st);
        if (op == 4'd4) begin
          rdVal = memRead(addr);
          reqQ.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
          c = '0; c.memRead = 1; c.iOrD = 1; applyStimulus(c, st);
          checkOutput("load stall cycles", 32'(st), 32'(lastLat));
          c = '0; c.regWrite = 1; c.memToReg = 1; applyStimulus(c, st);
          regs[rt] = rdVal;
        end else begin
          reqQ.push_back('{we: 1'b1, addr: addr, wdata: regs[rt]});
          c = '0; c.memWrite = 1; c.memRead = 1'($urandom); c.iOrD = 1; applyStimulus(c, st);
          checkOutput("store stall cycles", 32'(st), 32'(lastLat));
        end
      end
      4'd6: begin
        c = '0; c.aluSrcA = 1; c.aluSrcB = 2'd0; c.pcWriteCond = 1; c.pcSource = 2'd1;
        applyStimulus(c, st);
        if (regs[rs] == regs[rt]) pc = pc + sx;
      end
      4'd7: begin
        c = '0; c.pcWrite = 1; c.pcSource = 2'd2; applyStimulus(c, st);
        pc = {pc[15:12], instr[11:0]};
      end
      4'd8: begin
        c = '0; c.pcWrite = 1; c.pcSource = 2'd3; applyStimulus(c, st);
        pc = regs[rs];
      end
      4'd9: begin
        c = '0; c.aluSrcA = 0; c.aluSrcB = 2'd3; applyStimulus(c, st);
        c = '0; c.regWrite = 1; c.regDst = 2'd2; applyStimulus(c, st);
        regs[3] = pc;
      end
      default: begin
        outQ.push_back(regs[rs]);
        c = '0; c.outEn = 1; applyStimulus(c, st);
      end
    endcase
  endtask

  task automatic resetModel();
    pc = RST_PC;
    for (int i = 0; i < 4; i++) regs[i] = 16'h0;
    stallSum   = 0;
    fetchCount = 0;
  endtask

  task automatic runRandom(input int n);
    logic [3:0] op;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(1, 9));
      runInstr({op, 12'($urandom)});
    end
  endtask

  initial begin
    reset      = 1'b1;
    ctrl       = '0;
    forceReady = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("cyc_cnt in reset", cycCnt, 32'd0);
    checkOutput("instr_cnt in reset", instrCnt, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset mem_addr", 32'(memAddr), 32'(RST_PC));
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset mem_req", 32'(memReq), 32'd0);
    checkOutput("reset output_valid", 32'(outValid), 32'd0);
    checkOutput("reset inst_out", 32'(instOut), 32'd0);
    @(posedge clk);
    #1;

    fixedLat = 4;
    runInstr(16'h6A05);
    fixedLat = 0;
    runRandom(150);

    // Async reset while a fetch is waiting for memory.
    holdReady = 1;
    reqQ.push_back('{we: 1'b0, addr: pc, wdata: 16'h0});
    fetchWord = 16'h3000;
    isFetch   = 1;
    ctrl = '0; ctrl.memRead = 1; ctrl.irWrite = 1; ctrl.pcWrite = 1; ctrl.aluSrcB = 2'd1;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("mem_req before reset", 32'(memReq), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mem_req async reset", 32'(memReq), 32'd0);
    checkOutput("stall_cnt in reset", stallCnt, 32'd0);
    checkOutput("cyc_cnt after reset", cycCnt, 32'd0);
    ctrl      = '0;
    isFetch   = 0;
    holdReady = 0;
    resetModel();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    forceReady = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("idle ready stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    forceReady = 1'b0;
    checkOutput("idle ready mem_req", 32'(memReq), 32'd0);
    checkOutput("post-reset mem_addr", 32'(memAddr), 32'(RST_PC));

    runRandom(40);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("request queue drained", 32'(reqQ.size()), 32'd0);
    checkOutput("output queue drained", 32'(outQ.size()), 32'd0);
`ifdef DP_PERF_CNT_EN
    checkOutput("instr_cnt", instrCnt, 32'(fetchCount));
    checkOutput("stall_cnt", stallCnt, 32'(stallSum));
`else
    checkOutput("instr_cnt tied", instrCnt, 32'd0);
    checkOutput("stall_cnt tied", stallCnt, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
